pheap_sched: RTL and testbench

- Front-end scheduler for the pipelined min-heap event queue.
- Arbitrates enqueue and dequeue requests from N simulation cores onto the heap's single enq/deq/inp_data port.
- Enforces the heap's issue-spacing rules and routes the dequeued minimum event back to the requesting core.
- Exports the current heap minimum timestamp for GVT computation.

---
 rtl/pheap_sched.sv | 160 ++++++++++++++++
 tb/tb_pheap_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pheap_sched.sv
// rtl/pheap_sched.sv - N-core round-robin front end for the pipelined min-heap
//
// Purpose:
//   Arbitrates per-core enqueue/dequeue requests onto the heap's single
//   enq/deq/inp_data port, spaces heap operations by ISSUE_GAP idle cycles,
//   returns dequeued events to the requesting core one cycle after grant, and
//   exports the current heap minimum timestamp for GVT computation.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_enq/req_deq [N]   per-core requests, held by the core until granted
//   req_data [N*WIDTH]    per-core event word, core i at [i*WIDTH +: WIDTH]
//   grant [N]             combinational one-hot accept pulse
//   rsp_vld [N]           registered one-hot dequeue response valid
//   rsp_data [WIDTH]      registered dequeued event, shared by all cores
//   hold                  blocks dequeue grants (GVT freeze)
//   min_ts, min_vld       current heap minimum timestamp and its valid
//   heap_enq/deq/data     command port to the heap
//   heap_out/full/empty/ready  status from the heap

module pheap_sched #(
  parameter int N         = 4,
  parameter int WIDTH     = 32,
  parameter int CMP_WID   = 32,
  parameter int DEPTH     = 5,
  parameter int ISSUE_GAP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_enq,
  input  logic [N-1:0]         req_deq,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         rsp_vld,
  output logic [WIDTH-1:0]     rsp_data,
  input  logic                 hold,
  output logic [CMP_WID-1:0]   min_ts,
  output logic                 min_vld,
  output logic                 heap_enq,
  output logic                 heap_deq,
  output logic [WIDTH-1:0]     heap_data,
  input  logic [WIDTH-1:0]     heap_out,
  input  logic                 heap_full,
  input  logic                 heap_empty,
  input  logic                 heap_ready
);

  localparam int PW = $clog2(N);
  localparam logic [1:0]    GAP_LAST = (ISSUE_GAP > 0) ? 2'(ISSUE_GAP - 1) : 2'd0;
  localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);

  if (N < 2 || N > 8 || ISSUE_GAP < 0 || ISSUE_GAP > 3 || DEPTH < 1 ||
      CMP_WID < 1 || CMP_WID > WIDTH) begin : g_bad_param
    $error("pheap_sched: parameter out of range");
  end

  typedef enum logic {ARB = 1'b0, GAP = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_gap_cnt;
  logic [PW-1:0]     r_rr_ptr;
  logic [N-1:0]      r_rsp_vld;
  logic [WIDTH-1:0]  r_rsp_data;

  logic [N-1:0]      w_elig;
  logic              w_found;
  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_idx;
  logic              w_issue;
  logic              w_is_enq;

  // Eligibility: an enqueue needs room, a dequeue needs an event and no freeze.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_elig[i] = (req_enq[i] && !heap_full) ||
                  (req_deq[i] && !heap_empty && !hold);
    end
  end

  // Round-robin search starting at r_rr_ptr; first eligible core wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(r_rr_ptr) + k) % N);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_issue  = !rst && (r_state == ARB) && heap_ready && w_found;
  // Enqueue has priority when a core presents both eligible requests.
  assign w_is_enq = req_enq[w_win] && !heap_full;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB: if (w_issue && (ISSUE_GAP > 0)) w_state_nxt = GAP;
      GAP: if (r_gap_cnt == GAP_LAST)      w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // FSM outputs: grant and heap command, all combinational in the issue cycle
  always_comb begin
    grant     = '0;
    heap_enq  = 1'b0;
    heap_deq  = 1'b0;
    heap_data = '0;
    if (w_issue) begin
      grant[w_win] = 1'b1;
      if (w_is_enq) begin
        heap_enq  = 1'b1;
        heap_data = req_data[w_win*WIDTH +: WIDTH];
      end else begin
        heap_deq  = 1'b1;
      end
    end
  end

  // Gap counter, round-robin pointer and dequeue response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap_cnt  <= '0;
      r_rr_ptr   <= '0;
      r_rsp_vld  <= '0;
      r_rsp_data <= '0;
    end else begin
      r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 2'd1 : 2'd0;
      r_rsp_vld <= '0;
      if (w_issue) begin
        r_rr_ptr <= (w_win == PTR_LAST) ? '0 : w_win + 1'b1;
        if (!w_is_enq) begin
          r_rsp_vld[w_win] <= 1'b1;
          r_rsp_data       <= heap_out;
        end
      end
    end
  end

  assign rsp_vld  = r_rsp_vld;
  assign rsp_data = r_rsp_data;
  assign min_vld  = ~heap_empty;
  assign min_ts   = heap_empty ? '0 : heap_out[CMP_WID-1:0];

endmodule

// File: tb/tb_pheap_sched.sv
// tb/tb_pheap_sched.sv - self-checking bench for pheap_sched with a behavioural heap
module tb_pheap_sched;
  localparam int N = 4, WIDTH = 32, CMP_WID = 32, DEPTH = 5, ISSUE_GAP = 1, CAP = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_enq, req_deq;
  logic [N*WIDTH-1:0]   req_data;
  logic                 hold;
  logic [N-1:0]         grant, rsp_vld;
  logic [WIDTH-1:0]     rsp_data, heap_data;
  logic [CMP_WID-1:0]   min_ts;
  logic                 min_vld, heap_enq, heap_deq;
  logic [WIDTH-1:0]     heap_out = '0;
  logic                 heap_empty = 1'b1;
  logic                 heap_ready = 1'b1;
  logic                 cap_full = 1'b0;
  logic                 force_full = 1'b0;
  logic                 clr_heap = 1'b0;
  logic                 heap_full;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pheap_sched #(.N(N), .WIDTH(WIDTH), .CMP_WID(CMP_WID), .DEPTH(DEPTH), .ISSUE_GAP(ISSUE_GAP)) dut (
    .clk(clk), .rst(rst), .req_enq(req_enq), .req_deq(req_deq), .req_data(req_data),
    .grant(grant), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .hold(hold),
    .min_ts(min_ts), .min_vld(min_vld), .heap_enq(heap_enq), .heap_deq(heap_deq),
    .heap_data(heap_data), .heap_out(heap_out), .heap_full(heap_full),
    .heap_empty(heap_empty), .heap_ready(heap_ready)
  );

  // Behavioural heap: sorted queue, minimum at the front, busy the cycle after an enq.
  logic [WIDTH-1:0] hq[$];
  assign heap_full = force_full | cap_full;
  always @(posedge clk) begin
    int pos;
    if (clr_heap) begin
      hq.delete();
    end else begin
      if (heap_deq && hq.size() > 0) hq.delete(0);
      if (heap_enq) begin
        pos = hq.size();
        for (int i = hq.size() - 1; i >= 0; i--) if (heap_data < hq[i]) pos = i;
        hq.insert(pos, heap_data);
      end
    end
    heap_out   <= (hq.size() > 0) ? hq[0] : '0;
    heap_empty <= (hq.size() == 0);
    cap_full   <= (hq.size() >= CAP);
    heap_ready <= !heap_enq;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scheduler model: time-since-last-issue spacing plus rotating priority.
  int               m_ptr = 0;
  int               m_since = ISSUE_GAP;
  logic [N-1:0]     m_rsp_vld = '0;
  logic [WIDTH-1:0] m_rsp_data = '0;

  always @(negedge clk) begin
    logic [N-1:0]     e_grant;
    logic             e_enq, e_deq;
    logic [WIDTH-1:0] e_data;
    int w, c;
    e_grant = '0; e_enq = 1'b0; e_deq = 1'b0; e_data = '0; w = -1;
    if (!rst && heap_ready && m_since >= ISSUE_GAP) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (w < 0 && ((req_enq[c] && !heap_full) || (req_deq[c] && !heap_empty && !hold))) w = c;
      end
    end
    if (w >= 0) begin
      e_grant[w] = 1'b1;
      if (req_enq[w] && !heap_full) begin
        e_enq = 1'b1;
        e_data = req_data[w*WIDTH +: WIDTH];
      end else begin
        e_deq = 1'b1;
      end
    end
    chk("m_grant", grant, e_grant);
    chk("m_heap_enq", heap_enq, e_enq);
    chk("m_heap_deq", heap_deq, e_deq);
    chk("m_heap_data", heap_data, e_data);
    chk("m_rsp_vld", rsp_vld, m_rsp_vld);
    chk("m_rsp_data", rsp_data, m_rsp_data);
    chk("m_min_vld", min_vld, !heap_empty);
    chk("m_min_ts", min_ts, heap_empty ? '0 : heap_out[CMP_WID-1:0]);
    if (rst) begin
      m_ptr = 0; m_since = ISSUE_GAP; m_rsp_vld = '0; m_rsp_data = '0;
    end else begin
      m_rsp_vld = '0;
      if (w >= 0) begin
        m_ptr = (w + 1) % N;
        m_since = 0;
        if (e_deq) begin
          m_rsp_vld[w] = 1'b1;
          m_rsp_data = heap_out;
        end
      end else if (m_since < ISSUE_GAP) begin
        m_since++;
      end
    end
  end

  // Directed stimulus; tasks start and end just after a rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(input int c);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (grant[c]) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_grant core%0d: no grant within 40 cycles", c);
    end
  endtask

  task automatic do_enq(input int c, input logic [WIDTH-1:0] d);
    req_data[c*WIDTH +: WIDTH] = d;
    req_enq[c] = 1'b1;
    wait_grant(c);
    chk("enq_heap_data", heap_data, d);
    tick();
    req_enq[c] = 1'b0;
  endtask

  task automatic do_deq(input int c, input logic [WIDTH-1:0] exp);
    logic [N-1:0] ev;
    req_deq[c] = 1'b1;
    wait_grant(c);
    chk("deq_heap_deq", heap_deq, 1);
    tick();
    req_deq[c] = 1'b0;
    @(negedge clk);
    ev = '0; ev[c] = 1'b1;
    chk("deq_rsp_vld", rsp_vld, ev);
    chk("deq_rsp_data", rsp_data, exp);
    tick();
  endtask

  task automatic clear_heap();
    clr_heap = 1'b1;
    tick();
    clr_heap = 1'b0;
    tick();
  endtask

  initial begin
    logic [N-1:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    rst = 1'b1; req_enq = '0; req_deq = '0; req_data = '0; hold = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_heap_enq", heap_enq, 0);
    chk("rst_heap_deq", heap_deq, 0);
    chk("rst_heap_data", heap_data, 0);
    tick();
    rst = 1'b0;

    // Single enq from core2, then a gap cycle
    req_data[2*WIDTH +: WIDTH] = 32'h10;
    req_enq[2] = 1'b1;
    @(negedge clk);
    chk("t1_grant", grant, 4'b0100);
    chk("t1_heap_enq", heap_enq, 1);
    chk("t1_heap_data", heap_data, 32'h10);
    tick();
    req_enq[2] = 1'b0;
    @(negedge clk);
    chk("t1_gap_grant", grant, 0);
    chk("t1_gap_enq", heap_enq, 0);
    tick();

    // Pointer now at 3: core3 beats core0
    req_data[0 +: WIDTH] = 32'h1;
    req_data[3*WIDTH +: WIDTH] = 32'h2;
    req_enq = 4'b1001;
    @(negedge clk);
    chk("ptr3_grant", grant, 4'b1000);
    tick();
    req_enq = '0;
    tick();

    // Round robin with all four cores requesting, wrap to core0
    for (int i = 0; i < N; i++) req_data[i*WIDTH +: WIDTH] = 32'h100 + i;
    req_enq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_grant", grant, rr_exp[i]);
      tick();
      @(negedge clk);
      chk("rr_idle", grant, 0);
      tick();
    end
    req_enq = '0;
    clear_heap();

    // Dequeue path returns events in timestamp order
    do_enq(0, 32'h30);
    do_enq(1, 32'h10);
    do_enq(2, 32'h20);
    tick();
    do_deq(3, 32'h10);
    do_deq(3, 32'h20);
    do_deq(3, 32'h30);
    @(negedge clk);
    chk("rsp_data_hold", rsp_data, 32'h30);
    chk("rsp_vld_clear", rsp_vld, 0);
    tick();

    // Empty heap blocks the dequeue until core0's enq lands
    req_deq[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("empty_no_grant", grant, 0);
      tick();
    end
    do_enq(0, 32'h5);
    wait_grant(1);
    tick();
    req_deq[1] = 1'b0;
    @(negedge clk);
    chk("empty_rsp_vld", rsp_vld, 4'b0010);
    chk("empty_rsp_data", rsp_data, 32'h5);
    tick();

    // Full heap blocks every enqueue
    force_full = 1'b1;
    req_enq = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("full_no_grant", grant, 0);
      tick();
    end
    req_enq = '0;
    force_full = 1'b0;
    clear_heap();

    // Hold freezes the dequeue, enqueue proceeds
    do_enq(2, 32'h7);
    tick();
    hold = 1'b1;
    req_deq[0] = 1'b1;
    req_data[1*WIDTH +: WIDTH] = 32'h3;
    req_enq[1] = 1'b1;
    wait_grant(1);
    chk("hold_grant", grant, 4'b0010);
    tick();
    req_enq[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_no_grant", grant, 0);
      tick();
    end
    @(negedge clk);
    chk("hold_min_ts", min_ts, 32'h3);
    chk("hold_min_vld", min_vld, 1);
    tick();
    hold = 1'b0;
    wait_grant(0);
    tick();
    req_deq[0] = 1'b0;
    @(negedge clk);
    chk("hold_rsp_vld", rsp_vld, 4'b0001);
    chk("hold_rsp_data", rsp_data, 32'h3);
    tick();

    // Reset in the cycle after a dequeue grant
    req_deq[2] = 1'b1;
    wait_grant(2);
    tick();
    req_deq[2] = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mrst_rsp_vld", rsp_vld, 0);
    chk("mrst_grant", grant, 0);
    chk("mrst_heap_enq", heap_enq, 0);
    chk("mrst_heap_deq", heap_deq, 0);
    tick();
    rst = 1'b0;
    req_enq = 4'b1111;
    @(negedge clk);
    chk("mrst_ptr0_grant", grant, 4'b0001);
    tick();
    req_enq = '0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
